ulpi_reg_ctrl: RTL and testbench
================================

Name: ulpi_reg_ctrl

Overview:
- Single-clock controller for the ULPI link-side TX path, in the 60MHz ULPI clock domain next to the PCB-004 pin wrapper.
- After PHY reset release, waits for the PHY to come up, then writes a parameterised init table into PHY registers.
- Afterwards, arbitrates the ULPI TX bus between the USB link (pass-through) and a register read/write request port, with abort-retry and timeout.

Parameters:
- N_INIT, 2, number of init-table register writes (1..16).
- INIT_ADDR, {6'h0A,6'h04}, packed N_INIT×6b addresses; entry 0 in the LSBs.
- INIT_DATA, {8'h00,8'h45}, packed N_INIT×8b write data; entry 0 in the LSBs.
- STABLE_CYCLES, 64, consecutive dir-low cycles required before the init sequence starts.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for nxt or dir in any state.
- MAX_RETRY, 3, aborted attempts before an error response.

Ports:
- i_clk  in  1  ULPI clock from the PHY.
- i_rstn  in  1  asynchronous active-low reset.
- i_ulpi_dir  in  1  PHY dir.
- i_ulpi_nxt  in  1  PHY nxt.
- i_ulpi_data  in  8  PHY-to-link data.
- o_ulpi_stp  out  1  stp to PHY.
- o_ulpi_data  out  8  link-to-PHY data.
- i_link_stp  in  1  link stp, passed through when granted.
- i_link_data  in  8  link data, passed through when granted.
- i_link_busy  in  1  link is mid-transmit; the controller must not take the bus.
- o_link_gnt  out  1  link owns the TX bus.
- i_req_valid  in  1  register request valid.
- o_req_ready  out  1  request accepted this cycle.
- i_req_write  in  1  1 = write, 0 = read.
- i_req_addr  in  6  register address.
- i_req_wdata  in  8  write data.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  8  read data; 0 for writes.
- o_rsp_err  out  1  request failed (retries exhausted or timeout).
- o_initDone  out  1  init table complete; level.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=WAIT_PHY; o_ulpi_data=0; o_ulpi_stp=0; o_link_gnt=0; o_req_ready=0; o_rsp_*=0; o_initDone=0; counters=0.
- TX mux:
  - o_link_gnt=1 only in IDLE.
  - When granted, o_ulpi_data/stp = i_link_data/stp; otherwise the FSM drives them.
  - In all turnaround/dir=1 states, FSM drives data=0 and stp=0.
- WAIT_PHY:
  - Stable counter increments while dir=0 and clears on dir=1.
  - At STABLE_CYCLES → INIT_ISSUE with init index 0.
- INIT_ISSUE:
  - Loads addr/data from table[index] as a write.
  - Goes to CMD.
- IDLE:
  - Requires i_link_busy=0 and dir=0 to start anything.
  - If i_req_valid is high, o_req_ready=1 for one cycle; the request is captured and next state is CMD.
  - o_req_ready is gated by o_initDone: no requests are accepted before init completes.
- CMD:
  - Drives TXCMD {2'b10,addr} for a write or {2'b11,addr} for a read.
  - Holds until nxt=1.
  - Write → WDATA; read → RTURN1.
- WDATA:
  - Drives wdata until nxt=1, then → WSTP.
- WSTP:
  - One cycle with stp=1 and data=0.
  - Then goes to RESP (host request) or advances the init index.
  - After the last init entry: o_initDone=1 → IDLE.
- RTURN1: expects dir=1 this cycle, then → RDATA.
- RDATA: captures i_ulpi_data into rdata → RTURN2.
- RTURN2: waits for dir=0 → RESP.
- RESP: o_rsp_valid=1 for one cycle with rdata/err → IDLE.
- Total latency, write with immediate nxt: accept→CMD(1)→WDATA(1)→WSTP(1)→RESP; o_rsp_valid 4 cycles after o_req_ready.
- Total latency, read: accept→CMD→RTURN1→RDATA→RTURN2→RESP; o_rsp_valid 5 cycles after o_req_ready.
- Abort:
  - dir rising while in CMD or WDATA (PHY RX event) → ABORT.
  - ABORT drives data=0, waits for dir=0, increments retry, then reissues CMD.
  - If retry exceeds MAX_RETRY → RESP with err=1.
  - During init, err instead skips the entry; o_initDone still asserts at the end.
- Timeout:
  - Per-state counter clears on every state change.
  - Reaching TIMEOUT_CYCLES in CMD, WDATA, RTURN2 or ABORT → RESP with err=1 (init: skip the entry).
  - In RTURN1, dir=0 is treated as an immediate abort.
- Simultaneous events:
  - dir=1 together with nxt=1 in CMD is an abort; dir wins.
  - i_link_busy rising in the same cycle as a request: link wins and no ready is issued.
- Mid-operation reset returns to WAIT_PHY; initDone is cleared and init reruns.

Decomposition:
- Package ulpi_pkg:
  - FSM state enum.
  - TXCMD prefix constants REGW=2'b10, REGR=2'b11.
  - Register address constants FUNC_CTRL=6'h04, OTG_CTRL=6'h0A.
- Sub-module: ulpi_txmux, the combinational grant/pass-through mux. All sequencing stays in the top module.

Test Plan:
- Init: hold dir=0, PHY model asserts nxt the cycle after each CMD/WDATA → bus sees 0x84, 0x45, stp; then 0x8A, 0x00, stp. o_initDone=1 after 64+~8 cycles.
- Host read addr 0x00, PHY returns 0x24 → TXCMD 0xC0; o_rsp_valid 5 cycles after ready with rdata=0x24, err=0.
- Host write 0x16=0x5A with PHY nxt delayed 3 cycles in CMD → data held at 0x96 for 4 cycles; o_rsp_valid with err=0.
- Abort: dir rises during WDATA 3 times, then a clean attempt → 3 reissued 0x84 TXCMDs, rsp err=0; a 4th abort instead gives err=1.
- Timeout: nxt never asserted → o_rsp_valid with err=1 exactly TIMEOUT_CYCLES after CMD entry.
- Arbitration: i_link_busy=1 with req pending → o_link_gnt=1, link data 0x40 appears on the bus, no ready; busy drops → ready on the next cycle. Reset mid-read → outputs return to reset values and o_initDone=0.

Source files
------------

// File: rtl/ulpi_pkg.sv
// Shared types and constants for the ULPI register controller.
// TXCMD prefixes and the PHY register addresses used by the default init table.
package ulpi_pkg;

  typedef enum logic [3:0] {
    StWaitPhy,
    StInitIssue,
    StIdle,
    StCmd,
    StWdata,
    StWstp,
    StRturn1,
    StRdata,
    StRturn2,
    StAbort,
    StResp
  } state_e;

  localparam logic [1:0] REGW = 2'b10;
  localparam logic [1:0] REGR = 2'b11;

  localparam logic [5:0] FUNC_CTRL = 6'h04;
  localparam logic [5:0] OTG_CTRL  = 6'h0A;

  function automatic logic [7:0] txcmd(input logic write, input logic [5:0] addr);
    return {write ? REGW : REGR, addr};
  endfunction

endpackage

// File: rtl/ulpi_txmux.sv
// Combinational TX bus mux: the link passes straight through while granted,
// otherwise the controller's registered drive owns the bus.
module ulpi_txmux (
  input  logic       gnt_i,
  input  logic       link_stp_i,
  input  logic [7:0] link_data_i,
  input  logic       fsm_stp_i,
  input  logic [7:0] fsm_data_i,
  output logic       ulpi_stp_o,
  output logic [7:0] ulpi_data_o
);

  always_comb begin
    ulpi_stp_o  = gnt_i ? link_stp_i  : fsm_stp_i;
    ulpi_data_o = gnt_i ? link_data_i : fsm_data_i;
  end

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register controller: waits for the PHY, writes the init table,
// then arbitrates the TX bus between the link and register requests.
module ulpi_reg_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned         N_INIT         = 2,
  parameter logic [N_INIT*6-1:0] INIT_ADDR      = {OTG_CTRL, FUNC_CTRL},
  parameter logic [N_INIT*8-1:0] INIT_DATA      = {8'h00, 8'h45},
  parameter int unsigned         STABLE_CYCLES  = 64,
  parameter int unsigned         TIMEOUT_CYCLES = 255,
  parameter int unsigned         MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_ulpi_dir,
  input  logic       i_ulpi_nxt,
  input  logic [7:0] i_ulpi_data,
  output logic       o_ulpi_stp,
  output logic [7:0] o_ulpi_data,
  input  logic       i_link_stp,
  input  logic [7:0] i_link_data,
  input  logic       i_link_busy,
  output logic       o_link_gnt,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_write,
  input  logic [5:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_err,
  output logic       o_initDone
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned StbW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RtyW = $clog2(MAX_RETRY + 2);

  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [StbW-1:0] StbLast = StbW'(STABLE_CYCLES - 1);
  localparam logic [RtyW-1:0] RtyMax  = RtyW'(MAX_RETRY);
  localparam logic [3:0]      IdxLast = 4'(N_INIT - 1);

  state_e          state_q, state_d;
  logic [StbW-1:0] stable_q, stable_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [RtyW-1:0] retry_q, retry_d;
  logic [3:0]      idx_q, idx_d;
  logic            write_q, write_d;
  logic [5:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            init_done_q, init_done_d;
  logic            gnt_q, gnt_d;
  logic [7:0]      fsm_data_q, fsm_data_d;
  logic            fsm_stp_q, fsm_stp_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            req_ready;
  logic            tmo_hit;
  logic            fail;
  logic            done;
  logic [5:0]      init_addr;
  logic [7:0]      init_wdata;

  always_comb begin
    init_addr  = '0;
    init_wdata = '0;
    for (int unsigned i = 0; i < N_INIT; i++) begin
      if (idx_q == 4'(i)) begin
        init_addr  = INIT_ADDR[i*6 +: 6];
        init_wdata = INIT_DATA[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    retry_d     = retry_q;
    idx_d       = idx_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    req_ready   = 1'b0;
    fail        = 1'b0;
    done        = 1'b0;
    tmo_hit     = (tmo_q == TmoLast);

    unique case (state_q)
      StWaitPhy: begin
        if (i_ulpi_dir) begin
          stable_d = '0;
        end else if (stable_q == StbLast) begin
          stable_d = '0;
          idx_d    = '0;
          state_d  = StInitIssue;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      StInitIssue: begin
        write_d = 1'b1;
        addr_d  = init_addr;
        wdata_d = init_wdata;
        rdata_d = '0;
        err_d   = 1'b0;
        retry_d = '0;
        state_d = StCmd;
      end
      StIdle: begin
        // Link activity always wins the bus over a pending register request.
        if (init_done_q && !i_link_busy && !i_ulpi_dir && i_req_valid) begin
          req_ready = 1'b1;
          write_d   = i_req_write;
          addr_d    = i_req_addr;
          wdata_d   = i_req_wdata;
          rdata_d   = '0;
          err_d     = 1'b0;
          retry_d   = '0;
          state_d   = StCmd;
        end
      end
      StCmd: begin
        if (i_ulpi_dir)      state_d = StAbort;
        else if (i_ulpi_nxt) state_d = write_q ? StWdata : StRturn1;
        else if (tmo_hit)    fail    = 1'b1;
      end
      StWdata: begin
        if (i_ulpi_dir)      state_d = StAbort;
        else if (i_ulpi_nxt) state_d = StWstp;
        else if (tmo_hit)    fail    = 1'b1;
      end
      StWstp:   done    = 1'b1;
      StRturn1: state_d = i_ulpi_dir ? StRdata : StAbort;
      StRdata: begin
        rdata_d = i_ulpi_data;
        state_d = StRturn2;
      end
      StRturn2: begin
        if (!i_ulpi_dir)  state_d = StResp;
        else if (tmo_hit) fail    = 1'b1;
      end
      StAbort: begin
        if (!i_ulpi_dir) begin
          if (retry_q == RtyMax) begin
            fail = 1'b1;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StCmd;
          end
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StWaitPhy;
    endcase

    if (fail) err_d = 1'b1;

    // A failed init entry is skipped exactly like a completed one.
    if (fail || done) begin
      if (!init_done_q) begin
        if (idx_q == IdxLast) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StInitIssue;
        end
      end else begin
        state_d = StResp;
      end
    end

    if (state_d != state_q) tmo_d = '0;
    else if (tmo_q != '1)   tmo_d = tmo_q + 1'b1;
    else                    tmo_d = tmo_q;

    fsm_data_d = '0;
    fsm_stp_d  = 1'b0;
    case (state_d)
      StCmd:   fsm_data_d = txcmd(write_d, addr_d);
      StWdata: fsm_data_d = wdata_d;
      StWstp:  fsm_stp_d  = 1'b1;
      default: ;
    endcase
    gnt_d       = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    rsp_rdata_d = rsp_valid_d ? rdata_d : '0;
    rsp_err_d   = rsp_valid_d & err_d;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= StWaitPhy;
      stable_q    <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      gnt_q       <= 1'b0;
      fsm_data_q  <= '0;
      fsm_stp_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      gnt_q       <= gnt_d;
      fsm_data_q  <= fsm_data_d;
      fsm_stp_q   <= fsm_stp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  ulpi_txmux u_txmux (
    .gnt_i       (gnt_q),
    .link_stp_i  (i_link_stp),
    .link_data_i (i_link_data),
    .fsm_stp_i   (fsm_stp_q),
    .fsm_data_i  (fsm_data_q),
    .ulpi_stp_o  (o_ulpi_stp),
    .ulpi_data_o (o_ulpi_data)
  );

  assign o_link_gnt  = gnt_q;
  assign o_req_ready = req_ready;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_initDone  = init_done_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Bench for ulpi_reg_ctrl: init trace, table-driven and random register transactions
// against a scripted PHY, arbitration, and reset mid-read.
module tb_ulpi_reg_ctrl;

  localparam int NInit  = 2;
  localparam int Stable = 64;
  localparam int MaxRty = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       dir, nxt, stp_o, gnt, link_stp, link_busy;
  logic       req_valid, req_ready, req_write, rsp_valid, rsp_err, init_done;
  logic [7:0] phy_data, bus_data, link_data, req_wdata, rsp_rdata;
  logic [5:0] req_addr;

  int n_vec = 0;
  int n_bad = 0;

  logic [5:0] tb_init_addr [NInit] = '{6'h04, 6'h0A};
  logic [7:0] tb_init_data [NInit] = '{8'h45, 8'h00};

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wd;
    int         delay;
    int         aborts;
    logic [7:0] rd;
    logic [7:0] e_cmd;
    logic       e_err;
    logic [7:0] e_rdata;
    int         e_lat;
    int         e_hold;
    int         e_eps;
  } vec_t;

  always #5 clk = ~clk;

  ulpi_reg_ctrl #(
    .N_INIT         (NInit),
    .INIT_ADDR      ({6'h0A, 6'h04}),
    .INIT_DATA      ({8'h00, 8'h45}),
    .STABLE_CYCLES  (Stable),
    .TIMEOUT_CYCLES (255),
    .MAX_RETRY      (MaxRty)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_ulpi_dir  (dir),
    .i_ulpi_nxt  (nxt),
    .i_ulpi_data (phy_data),
    .o_ulpi_stp  (stp_o),
    .o_ulpi_data (bus_data),
    .i_link_stp  (link_stp),
    .i_link_data (link_data),
    .i_link_busy (link_busy),
    .o_link_gnt  (gnt),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_initDone  (init_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected outcome from the protocol rules: each aborted write attempt costs
  // CMD hold + WDATA + ABORT, each aborted read attempt costs CMD + ABORT.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   failed = (v.aborts > MaxRty) ? MaxRty + 1 : v.aborts;
    r.e_err   = (v.aborts > MaxRty);
    r.e_cmd   = {v.wr ? 2'b10 : 2'b11, v.addr};
    r.e_rdata = (!v.wr && !r.e_err) ? v.rd : 8'h00;
    r.e_lat   = failed * (v.wr ? v.delay + 3 : 2)
              + (r.e_err ? 1 : (v.wr ? 4 : 5) + v.delay);
    r.e_hold  = failed * (v.wr ? v.delay + 1 : 1) + (r.e_err ? 0 : v.delay + 1);
    r.e_eps   = failed + (r.e_err ? 0 : 1);
    return r;
  endfunction

  task automatic run_init(input int glitch);
    logic [8:0] exp_trace[$];
    int         start = (glitch >= 0) ? glitch + 1 : 0;
    for (int w = 0; w < start + Stable; w++) exp_trace.push_back(9'h000);
    for (int e = 0; e < NInit; e++) begin
      exp_trace.push_back(9'h000);
      exp_trace.push_back({1'b0, 2'b10, tb_init_addr[e]});
      exp_trace.push_back({1'b0, tb_init_data[e]});
      exp_trace.push_back(9'h100);
    end
    for (int w = 0; w < exp_trace.size(); w++) begin
      @(negedge clk);
      dir       = (w == glitch);
      nxt       = 1'b1;
      req_valid = 1'b1;
      #1;
      chk($sformatf("init_bus[%0d]", w), {23'd0, stp_o, bus_data}, {23'd0, exp_trace[w]});
      chk($sformatf("init_noready[%0d]", w), req_ready, 0);
      chk($sformatf("init_notdone[%0d]", w), init_done, 0);
    end
    @(negedge clk);
    dir       = 1'b0;
    nxt       = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("init_done", init_done, 1);
    chk("init_gnt", gnt, 1);
  endtask

  task automatic xact(input string tag, input vec_t v);
    int r = -1, lat = -1, ab = v.aborts, cnt = 0, hold = 0, eps = 0, ph = 0;
    for (int w = 0; w < 1200 && lat < 0; w++) begin
      @(negedge clk);
      dir       = 1'b0;
      nxt       = 1'b0;
      phy_data  = 8'h00;
      req_valid = (r < 0);
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wd;
      if (!gnt) begin
        case (ph)
          0: if (bus_data == v.e_cmd && !stp_o) begin
            if (cnt == 0) eps++;
            cnt++;
            hold++;
            if (!v.wr && ab > 0) begin
              dir = 1'b1;
              nxt = 1'b1;
              ab--;
              ph  = 3;
              cnt = 0;
            end else if (cnt > v.delay) begin
              nxt = 1'b1;
              ph  = v.wr ? 1 : 4;
              cnt = 0;
            end
          end
          1: begin
            chk({tag, "_wdata"}, bus_data, v.wd);
            if (ab > 0) begin
              dir = 1'b1;
              ab--;
              ph  = 3;
            end else begin
              nxt = 1'b1;
              ph  = 2;
            end
          end
          2: begin
            chk({tag, "_stp"}, stp_o, 1);
            ph = 7;
          end
          3: ph = 0;
          4: begin
            dir = 1'b1;
            ph  = 5;
          end
          5: begin
            dir      = 1'b1;
            phy_data = v.rd;
            ph       = 6;
          end
          6: ph = 7;
          default: ;
        endcase
      end
      #1;
      if (req_ready && r < 0) r = w;
      if (rsp_valid && r >= 0) begin
        lat = w - r;
        chk({tag, "_lat"}, lat, v.e_lat);
        chk({tag, "_err"}, rsp_err, v.e_err);
        chk({tag, "_rdata"}, rsp_rdata, v.e_rdata);
        chk({tag, "_hold"}, hold, v.e_hold);
        chk({tag, "_txcmds"}, eps, v.e_eps);
      end
    end
    if (lat < 0) chk({tag, "_rsp_seen"}, 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({tag, "_rsp_pulse"}, rsp_valid, 0);
    chk({tag, "_back_idle"}, gnt, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    tbl[0] = '{1'b0, 6'h00, 8'h00, 0, 0, 8'h24, 8'hC0, 1'b0, 8'h24, 5, 1, 1};
    tbl[1] = '{1'b1, 6'h16, 8'h5A, 3, 0, 8'h00, 8'h96, 1'b0, 8'h00, 7, 4, 1};
    tbl[2] = '{1'b1, 6'h04, 8'h11, 0, 3, 8'h00, 8'h84, 1'b0, 8'h00, 13, 4, 4};
    tbl[3] = '{1'b1, 6'h04, 8'h22, 0, 4, 8'h00, 8'h84, 1'b1, 8'h00, 13, 4, 4};
    tbl[4] = '{1'b0, 6'h2A, 8'h00, 1, 2, 8'hE7, 8'hEA, 1'b0, 8'hE7, 10, 4, 3};
    tbl[5] = '{1'b0, 6'h3F, 8'h00, 0, 4, 8'h99, 8'hFF, 1'b1, 8'h00, 9, 4, 4};
    tbl[6] = '{1'b1, 6'h05, 8'h33, 1000, 0, 8'h00, 8'h85, 1'b1, 8'h00, 256, 255, 1};

    rstn      = 1'b0;
    dir       = 1'b0;
    nxt       = 1'b0;
    phy_data  = 8'h00;
    link_stp  = 1'b0;
    link_data = 8'h40;
    link_busy = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 6'h00;
    req_wdata = 8'h00;

    @(negedge clk);
    #1;
    chk("rst_bus", {23'd0, stp_o, bus_data}, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_done", init_done, 0);

    @(posedge clk);
    #2 rstn = 1'b1;
    run_init(-1);

    for (int i = 0; i < 7; i++) xact($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 30; i++) begin
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = 6'($urandom);
      v.wd     = 8'($urandom);
      v.delay  = int'($urandom_range(0, 3));
      v.aborts = int'($urandom_range(0, 5));
      v.rd     = 8'($urandom);
      xact($sformatf("rnd%0d", i), model(v));
    end

    // Link busy rises together with a request: the link keeps the bus.
    @(negedge clk);
    link_busy = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 6'h00;
    link_data = 8'h40;
    link_stp  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("arb_gnt", gnt, 1);
      chk("arb_bus", {23'd0, stp_o, bus_data}, 32'h140);
      chk("arb_noready", req_ready, 0);
    end
    @(negedge clk);
    link_busy = 1'b0;
    link_stp  = 1'b0;
    #1;
    chk("arb_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    nxt       = 1'b1;
    #1;
    chk("arb_rd_cmd", bus_data, 8'hC0);
    chk("arb_rd_nognt", gnt, 0);
    @(negedge clk);
    nxt       = 1'b0;
    dir       = 1'b1;
    req_valid = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("midrst_bus", {23'd0, stp_o, bus_data}, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("midrst_done", init_done, 0);
    @(negedge clk);
    dir       = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b1;
    run_init(10);
    xact("post_rst", tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
